// File: rtl/wb_arbiter_sb.sv
// Writeback arbiter between the ALU and LSU result paths, driving the GPR write port,
// with a per-register busy scoreboard for RAW/WAW hazard detection at issue.
module wb_arbiter_sb #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4,
  localparam int RW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn_h,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [RW-1:0]   iss_rd,
  input  logic [RW-1:0]   rs1n,
  input  logic [RW-1:0]   rs2n,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wbe,
  output logic [RW-1:0]   rdn,
  output logic [XLEN-1:0] rdd
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0]   r_starve_cnt;
  logic            r_wbe;
  logic [RW-1:0]   r_rdn;
  logic [XLEN-1:0] r_rdd;
  logic [NREG-1:0] r_busy;

  logic            w_alu_win;
  logic            w_lsu_win;
  logic            w_xfer;
  logic [RW-1:0]   w_xfer_rd;
  logic [XLEN-1:0] w_xfer_data;
  logic [CW-1:0]   w_starve_nxt;
  logic            w_iss_set;
  logic [NREG-1:0] w_busy_nxt;

  // Grant selection: LSU by default, ALU when LSU is idle or the ALU has starved too long.
  always_comb begin
    w_alu_win   = alu_valid & (~lsu_valid | (r_starve_cnt == STARVE_LIM));
    w_lsu_win   = lsu_valid & ~w_alu_win;
    w_xfer      = w_alu_win | w_lsu_win;
    w_xfer_rd   = {RW{1'b0}};
    w_xfer_data = {XLEN{1'b0}};
    if (w_alu_win) begin
      w_xfer_rd   = alu_rd;
      w_xfer_data = alu_data;
    end else begin
      w_xfer_rd   = lsu_rd;
      w_xfer_data = lsu_data;
    end
  end

  // Starvation count of consecutive ALU losses, saturating at the forcing threshold.
  always_comb begin
    w_starve_nxt = {CW{1'b0}};
    if (alu_valid & w_lsu_win) begin
      if (r_starve_cnt == STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt;
      end else begin
        w_starve_nxt = r_starve_cnt + CW'(1);
      end
    end else begin
      w_starve_nxt = {CW{1'b0}};
    end
  end

  // Scoreboard next state: the issue-side set is applied after the writeback clear so it wins.
  always_comb begin
    w_iss_set  = iss_valid & iss_ready & (iss_rd != {RW{1'b0}});
    w_busy_nxt = r_busy;
    if (r_wbe) begin
      w_busy_nxt[r_rdn] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_iss_set) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end else begin
      w_busy_nxt[0] = 1'b0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // State registers: starvation count, GPR write port and scoreboard.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      r_starve_cnt <= {CW{1'b0}};
      r_wbe        <= 1'b0;
      r_rdn        <= {RW{1'b0}};
      r_rdd        <= {XLEN{1'b0}};
      r_busy       <= {NREG{1'b0}};
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_busy       <= w_busy_nxt;
      if (w_xfer) begin
        r_wbe <= (w_xfer_rd != {RW{1'b0}});
        r_rdn <= w_xfer_rd;
        r_rdd <= w_xfer_data;
      end else begin
        r_wbe <= 1'b0;
      end
    end
  end

  assign alu_ready = w_alu_win;
  assign lsu_ready = w_lsu_win;
  // No bypass: a register being written this cycle still reads as busy until the edge.
  assign rs1_busy  = r_busy[rs1n];
  assign rs2_busy  = r_busy[rs2n];
  assign iss_ready = (iss_rd == {RW{1'b0}}) | ~r_busy[iss_rd];
  assign wbe       = r_wbe;
  assign rdn       = r_rdn;
  assign rdd       = r_rdd;

endmodule

// File: tb/tb_wb_arbiter_sb.sv
// Self-checking bench for wb_arbiter_sb: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of grants, writeback and busy bits.
module tb_wb_arbiter_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int SMAX = 4;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rstn_h;
  logic            alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [RW-1:0]   alu_rd, lsu_rd, iss_rd, rs1n, rs2n, rdn;
  logic [XLEN-1:0] alu_data, lsu_data, rdd;
  logic            iss_valid, iss_ready, rs1_busy, rs2_busy, wbe;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  bit           m_busy [NREG];
  int           m_losses;
  bit           m_wbe;
  int           m_rdn;
  logic [31:0]  m_rdd;

  // observed combinational values from the most recent cycle
  logic obs_alu_rdy, obs_lsu_rdy, obs_iss_rdy, obs_rs1, obs_rs2;

  wb_arbiter_sb #(.XLEN(XLEN), .NREG(NREG), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn_h(rstn_h),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .rs1n(rs1n), .rs2n(rs2n), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wbe(wbe), .rdn(rdn), .rdd(rdd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_losses = 0;
    m_wbe    = 1'b0;
    m_rdn    = 0;
    m_rdd    = 32'h0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'h0;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1n = 5'd0; rs2n = 5'd0;
  endtask

  // One clock cycle: inputs are set before the call (just after a falling edge).
  task automatic cycle();
    bit e_alu, e_lsu, e_iss;
    int wrd;
    logic [31:0] wdata;
    #2;
    e_alu = alu_valid && (!lsu_valid || m_losses == SMAX);
    e_lsu = lsu_valid && !e_alu;
    e_iss = (iss_rd == 5'd0) || !m_busy[iss_rd];
    obs_alu_rdy = alu_ready; obs_lsu_rdy = lsu_ready; obs_iss_rdy = iss_ready;
    obs_rs1 = rs1_busy; obs_rs2 = rs2_busy;
    chk("alu_ready", 32'(alu_ready), 32'(e_alu));
    chk("lsu_ready", 32'(lsu_ready), 32'(e_lsu));
    chk("iss_ready", 32'(iss_ready), 32'(e_iss));
    chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1n]));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2n]));
    @(posedge clk);
    if (m_wbe) m_busy[m_rdn] = 1'b0;
    if (iss_valid && e_iss && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    if (alu_valid && e_lsu) m_losses = (m_losses < SMAX) ? m_losses + 1 : SMAX;
    else m_losses = 0;
    if (e_alu || e_lsu) begin
      wrd   = e_alu ? int'(alu_rd) : int'(lsu_rd);
      wdata = e_alu ? alu_data : lsu_data;
      m_wbe = (wrd != 0);
      m_rdn = wrd;
      m_rdd = wdata;
    end else begin
      m_wbe = 1'b0;
    end
    #1;
    chk("wbe", 32'(wbe), 32'(m_wbe));
    chk("rdn", 32'(rdn), 32'(m_rdn));
    chk("rdd", rdd, m_rdd);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] grant_exp [6];
    logic [1:0] grant_obs;
    grant_exp[0] = 2'b01; grant_exp[1] = 2'b01; grant_exp[2] = 2'b01;
    grant_exp[3] = 2'b01; grant_exp[4] = 2'b10; grant_exp[5] = 2'b01;

    // reset state
    rstn_h = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wbe", 32'(wbe), 32'h0);
    chk("rst_rdn", 32'(rdn), 32'h0);
    chk("rst_rdd", rdd, 32'h0);
    rs1n = 5'd7; rs2n = 5'd31; #1;
    chk("rst_rs1", 32'(rs1_busy), 32'h0);
    chk("rst_rs2", 32'(rs2_busy), 32'h0);
    for (int i = 0; i < NREG; i += 7) begin
      iss_rd = 5'(i); #1;
      chk("rst_iss_ready", 32'(iss_ready), 32'h1);
    end
    @(negedge clk);
    rstn_h = 1'b1;
    idle_inputs();

    // ALU alone
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle();
    chk("alu_only_ready", 32'(obs_alu_rdy), 32'h1);
    chk("alu_only_wbe", 32'(wbe), 32'h1);
    chk("alu_only_rdn", 32'(rdn), 32'd5);
    chk("alu_only_rdd", rdd, 32'hDEAD_BEEF);
    idle_inputs();
    cycle();
    chk("alu_only_pulse", 32'(wbe), 32'h0);

    // contention for six cycles
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA000_0000 + 32'(c);
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB000_0000 + 32'(c);
      cycle();
      grant_obs = {obs_alu_rdy, obs_lsu_rdy};
      chk($sformatf("contention_grant%0d", c), 32'(grant_obs), 32'(grant_exp[c]));
    end
    idle_inputs();
    cycle();

    // scoreboard set, WAW block, LSU clear
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    iss_valid = 1'b0; rs1n = 5'd7;
    cycle();
    chk("sb_rs1_busy7", 32'(obs_rs1), 32'h1);
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    chk("sb_waw_block", 32'(obs_iss_rdy), 32'h0);
    iss_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_7777;
    cycle();
    lsu_valid = 1'b0;
    cycle();
    chk("sb_busy_until_edge", 32'(obs_rs1), 32'h1);
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    chk("sb_reissue_ok", 32'(obs_iss_rdy), 32'h1);
    idle_inputs();
    cycle();

    // set/clear collision on r9
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0909;
    cycle();
    chk("coll_wbe", 32'(wbe), 32'h1);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    iss_valid = 1'b0; rs2n = 5'd9;
    cycle();
    chk("coll_busy9", 32'(obs_rs2), 32'h1);

    // x0 destination
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
    cycle();
    chk("x0_ready", 32'(obs_alu_rdy), 32'h1);
    chk("x0_no_wbe", 32'(wbe), 32'h0);
    idle_inputs();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      alu_valid = 1'($urandom_range(0, 1));
      lsu_valid = 1'($urandom_range(0, 3) != 0);
      alu_rd    = 5'($urandom_range(0, 7));
      lsu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_data  = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      rs1n      = 5'($urandom_range(0, 7));
      rs2n      = 5'($urandom_range(0, 31));
      cycle();
    end

    // reset mid-operation
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hCAFE_F00D;
    iss_valid = 1'b1; iss_rd = 5'd13;
    cycle();
    idle_inputs();
    rs1n = 5'd13; rs2n = 5'd12; iss_rd = 5'd13;
    #1;
    chk("midrst_pre_wbe", 32'(wbe), 32'h1);
    chk("midrst_pre_busy", 32'(rs1_busy), 32'h1);
    rstn_h = 1'b0;
    #1;
    chk("midrst_wbe", 32'(wbe), 32'h0);
    chk("midrst_rdn", 32'(rdn), 32'h0);
    chk("midrst_rdd", rdd, 32'h0);
    chk("midrst_rs1", 32'(rs1_busy), 32'h0);
    chk("midrst_iss_ready", 32'(iss_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rstn_h = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
